// File: rtl/layer1_sequencer.sv
// layer1_sequencer: walks every (sample, neuron) pair through the layer-1 MAC,
// captures each IEEE-754 double activation and hands it to a valid/ready sink.
module layer1_sequencer #(
    parameter int NUM_SAMPLES = 4,
    parameter int NUM_NEURONS = 8,
    parameter int TIMEOUT     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        all_done,
    output logic        err_timeout,
    output logic [31:0] mac_i,
    output logic [31:0] mac_n,
    output logic        mac_j,
    output logic        mac_clr,
    input  logic [63:0] mac_act,
    input  logic        mac_done,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic [31:0] res_sample,
    output logic [31:0] res_neuron
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_WRITE,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] s_q, s_d;
    logic [31:0] n_q, n_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [63:0] data_q, data_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] rn_q, rn_d;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            rs_q    <= '0;
            rn_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            rn_q    <= rn_d;
        end
    end

    // Next-state logic: pair iteration, MAC watchdog and result capture.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        rs_d    = rs_q;
        rn_d    = rn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    s_d     = '0;
                    n_d     = '0;
                    err_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: begin
                cnt_d = cnt_q + 32'd1;
                // A done on the final allowed cycle still counts as a result.
                if (mac_done) begin
                    data_d  = mac_act;
                    rs_d    = s_q;
                    rn_d    = n_q;
                    state_d = S_WRITE;
                end else if (cnt_q + 32'd1 >= 32'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_WRITE: begin
                if (res_ready) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (n_q < 32'(NUM_NEURONS - 1)) begin
                    n_d     = n_q + 32'd1;
                    state_d = S_CLEAR;
                end else begin
                    n_d = '0;
                    if (s_q < 32'(NUM_SAMPLES - 1)) begin
                        s_d     = s_q + 32'd1;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q == S_CLEAR) || (state_q == S_RUN) ||
                         (state_q == S_WRITE) || (state_q == S_NEXT);
    assign all_done    = (state_q == S_DONE);
    assign err_timeout = err_q;
    assign mac_clr     = (state_q == S_CLEAR);
    assign mac_j       = (state_q != S_RUN);
    assign mac_i       = s_q;
    assign mac_n       = n_q;
    assign res_valid   = (state_q == S_WRITE);
    assign res_data    = data_q;
    assign res_sample  = rs_q;
    assign res_neuron  = rn_q;

endmodule

// File: tb/tb_layer1_sequencer.sv
// tb_layer1_sequencer: directed and randomized checks of layer1_sequencer
// against a behavioural MAC and a pair-order scoreboard.
module tb_layer1_sequencer;

    localparam int NS = 2;
    localparam int NN = 3;
    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, all_done, err_timeout, mac_j, mac_clr, res_valid;
    logic [31:0] mac_i, mac_n, res_sample, res_neuron;
    logic [63:0] mac_act = '0;
    logic        mac_done = 1'b0;
    logic        res_ready = 1'b1;
    logic [63:0] res_data;

    int checks = 0;
    int errors = 0;
    int runlen = 0;
    int done_cnt = 0;

    // MAC model controls
    int lat = 16;
    bit rnd_lat = 0;
    bit hang_en = 0;
    // Sink controls
    bit rdy_force = 0;
    bit rdy_val = 1;
    bit rdy_rand = 0;

    logic [31:0] q_s[$];
    logic [31:0] q_n[$];
    logic [63:0] q_d[$];

    layer1_sequencer #(
        .NUM_SAMPLES(NS),
        .NUM_NEURONS(NN),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .all_done(all_done), .err_timeout(err_timeout),
        .mac_i(mac_i), .mac_n(mac_n), .mac_j(mac_j), .mac_clr(mac_clr),
        .mac_act(mac_act), .mac_done(mac_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_sample(res_sample), .res_neuron(res_neuron)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: done rises after 'lat' enabled cycles; act = sample*16+neuron.
    int mcnt = 0;
    int cur_lat = 16;
    bit cur_hang = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            mcnt = 0;
            mac_done <= 1'b0;
        end else if (mac_clr) begin
            mcnt = 0;
            mac_done <= 1'b0;
            mac_act <= $realtobits(real'(int'(mac_i) * 16 + int'(mac_n)));
            cur_lat = rnd_lat ? int'($urandom_range(1, TO - 1)) : lat;
            cur_hang = hang_en && (mac_i == 32'd1) && (mac_n == 32'd0);
        end else if (!mac_j) begin
            mcnt++;
            if (!cur_hang && mcnt >= cur_lat) mac_done <= 1'b1;
        end
    end

    // Sink ready driver, updated away from the clock edge.
    always @(posedge clk) begin
        #3;
        res_ready = rdy_force ? rdy_val : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Transfer and all_done monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (all_done) done_cnt++;
            if (res_valid && res_ready) begin
                q_s.push_back(res_sample);
                q_n.push_back(res_neuron);
                q_d.push_back(res_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mac_clr) runlen = 0;
        else if (!mac_j) runlen++;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_sig(input int which, input int bound, output int k);
        bit hit;
        k = 0;
        hit = 0;
        while (!hit && k < bound) begin
            tick();
            k++;
            case (which)
                0: hit = all_done;
                1: hit = res_valid;
                2: hit = err_timeout;
                3: hit = (mac_i == 32'd1) && (mac_n == 32'd1) && !mac_j;
                default: hit = !mac_j;
            endcase
        end
        if (!hit) chk($sformatf("wait%0d_bound", which), 64'd0, 64'd1);
    endtask

    // Expected pass: neuron-minor, sample-major, act = s*16+n as a double.
    task automatic check_pass(input int base, input string tag);
        int idx;
        idx = base;
        chk({tag, "_count"}, 64'(q_s.size() - base), 64'(NS * NN));
        for (int s = 0; s < NS; s++) begin
            for (int n = 0; n < NN; n++) begin
                if (idx < q_s.size()) begin
                    chk($sformatf("%s_sample%0d", tag, idx - base), 64'(q_s[idx]), 64'(s));
                    chk($sformatf("%s_neuron%0d", tag, idx - base), 64'(q_n[idx]), 64'(n));
                    chk($sformatf("%s_data%0d", tag, idx - base), q_d[idx],
                        $realtobits(real'(s * 16 + n)));
                end
                idx++;
            end
        end
    endtask

    function automatic int pass_cycles(input int l);
        return NS * NN * (l + 4);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_all_done"}, 64'(all_done), 64'd0);
        chk({tag, "_err"}, 64'(err_timeout), 64'd0);
        chk({tag, "_mac_clr"}, 64'(mac_clr), 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_mac_j"}, 64'(mac_j), 64'd1);
        chk({tag, "_mac_i"}, 64'(mac_i), 64'd0);
        chk({tag, "_mac_n"}, 64'(mac_n), 64'd0);
        chk({tag, "_res_data"}, res_data, 64'd0);
        chk({tag, "_res_sample"}, 64'(res_sample), 64'd0);
        chk({tag, "_res_neuron"}, 64'(res_neuron), 64'd0);
    endtask

    initial begin
        int k, k1, k3, base, dbase;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Test 1: nominal pass, ready always high
        base = q_s.size();
        dbase = done_cnt;
        do_start();
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        chk("t1_clear_strobe", 64'(mac_clr), 64'd1);
        wait_sig(0, 1000, k);
        chk("t1_latency", 64'(k), 64'(pass_cycles(16)));
        chk("t1_busy_in_done", 64'(busy), 64'd0);
        tick();
        tick();
        chk("t1_busy_idle", 64'(busy), 64'd0);
        chk("t1_done_pulses", 64'(done_cnt - dbase), 64'd1);
        check_pass(base, "t1");

        // Test 2: back-pressure on the second result
        base = q_s.size();
        rdy_force = 1;
        rdy_val = 0;
        do_start();
        wait_sig(1, 100, k);
        rdy_val = 1;
        tick();
        rdy_val = 0;
        wait_sig(1, 100, k);
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid_held", 64'(res_valid), 64'd1);
            chk("t2_sample_held", 64'(res_sample), 64'd0);
            chk("t2_neuron_held", 64'(res_neuron), 64'd1);
            chk("t2_data_held", res_data, $realtobits(1.0));
            chk("t2_mac_i_held", 64'(mac_i), 64'd0);
            chk("t2_mac_n_held", 64'(mac_n), 64'd1);
            tick();
        end
        chk("t2_no_early_transfer", 64'(q_s.size() - base), 64'd1);
        rdy_force = 0;
        tick();
        chk("t2_valid_falls", 64'(res_valid), 64'd0);
        wait_sig(0, 1000, k);
        tick();
        check_pass(base, "t2");

        // Test 3: MAC hangs on pair (1,0) -> timeout abort, then clean restart
        base = q_s.size();
        hang_en = 1;
        do_start();
        wait_sig(2, 1000, k);
        chk("t3_run_cycles", 64'(runlen), 64'(TO));
        chk("t3_results_before", 64'(q_s.size() - base), 64'd3);
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_mac_j", 64'(mac_j), 64'd1);
        chk("t3_res_valid", 64'(res_valid), 64'd0);
        chk("t3_mac_i", 64'(mac_i), 64'd1);
        chk("t3_mac_n", 64'(mac_n), 64'd0);
        tick();
        tick();
        chk("t3_err_sticky", 64'(err_timeout), 64'd1);
        chk("t3_idle_busy", 64'(busy), 64'd0);
        hang_en = 0;
        base = q_s.size();
        do_start();
        chk("t3_err_cleared", 64'(err_timeout), 64'd0);
        chk("t3_restart_i", 64'(mac_i), 64'd0);
        chk("t3_restart_n", 64'(mac_n), 64'd0);
        wait_sig(0, 1000, k);
        tick();
        check_pass(base, "t3");

        // Test 4: start during RUN and on the DONE cycle is ignored
        base = q_s.size();
        dbase = done_cnt;
        do_start();
        wait_sig(4, 10, k1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_no_restart_clr", 64'(mac_clr), 64'd0);
        chk("t4_still_busy", 64'(busy), 64'd1);
        wait_sig(0, 1000, k3);
        chk("t4_latency", 64'(k1 + 1 + k3), 64'(pass_cycles(16)));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_done_start_ignored", 64'(busy), 64'd0);
        chk("t4_done_start_no_clr", 64'(mac_clr), 64'd0);
        tick();
        tick();
        chk("t4_idle", 64'(busy), 64'd0);
        chk("t4_done_pulses", 64'(done_cnt - dbase), 64'd1);
        check_pass(base, "t4");

        // Test 5: reset in the RUN of pair (1,1)
        base = q_s.size();
        do_start();
        wait_sig(3, 1000, k);
        chk("t5_results_before", 64'(q_s.size() - base), 64'd4);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("t5");
        rst_n = 1'b1;
        tick();
        base = q_s.size();
        do_start();
        chk("t5_restart_i", 64'(mac_i), 64'd0);
        chk("t5_restart_n", 64'(mac_n), 64'd0);
        chk("t5_restart_clr", 64'(mac_clr), 64'd1);
        wait_sig(0, 1000, k);
        tick();
        check_pass(base, "t5");

        // Test 6: done arrives on the last allowed RUN cycle
        base = q_s.size();
        lat = TO - 1;
        do_start();
        wait_sig(0, 1000, k);
        chk("t6_latency", 64'(k), 64'(pass_cycles(TO - 1)));
        chk("t6_no_error", 64'(err_timeout), 64'd0);
        tick();
        check_pass(base, "t6");
        lat = 16;

        // Randomized passes: random MAC latency and random sink stalls
        rnd_lat = 1;
        rdy_rand = 1;
        for (int p = 0; p < 3; p++) begin
            base = q_s.size();
            dbase = done_cnt;
            do_start();
            wait_sig(0, 2000, k);
            tick();
            tick();
            chk($sformatf("rnd%0d_no_error", p), 64'(err_timeout), 64'd0);
            chk($sformatf("rnd%0d_done_pulses", p), 64'(done_cnt - dbase), 64'd1);
            check_pass(base, $sformatf("rnd%0d", p));
        end
        rnd_lat = 0;
        rdy_rand = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
